// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
//   Two-stage elastic pipeline converting code words between Gray and
//   binary, one word per cycle. For Gray input words it also flags any word
//   that is not exactly one bit away from the previous Gray word.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   in_valid        upstream word present
//   in_ready        block accepts a word this cycle (combinational)
//   in_data         code word to convert (WIDTH bits)
//   in_mode         0 = Gray->binary, 1 = binary->Gray
//   seq_clr         synchronous clear of the Gray-sequence history
//   out_valid       result present
//   out_ready       downstream takes the result this cycle
//   out_data        converted word
//   out_mode        in_mode of the word that produced out_data
//   out_seq_err     Gray adjacency violation for the word in out_data
module gray_codec_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             seq_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_seq_err
);

    // S1: captured word plus its sequence flag
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_mode;
    logic             r_s1_err;

    // S2: converted result
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_mode;
    logic             r_s2_err;

    // Gray-sequence history
    logic [WIDTH-1:0] r_hist_word;
    logic             r_hist_vld;

    logic             w_xfer_in;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_diff;
    logic             w_dist_one;
    logic             w_hist_live;
    logic             w_seq_err;
    logic [WIDTH-1:0] w_g2b;
    logic [WIDTH-1:0] w_b2g;
    logic [WIDTH-1:0] w_conv;

    // Accept whenever the pipe can make room: either stage empty, or the
    // downstream drains S2 this cycle so S1 moves up.
    assign in_ready  = ~r_s1_vld | ~r_s2_vld | out_ready;
    assign w_xfer_in = in_valid & in_ready;
    assign w_s2_load = r_s1_vld & (~r_s2_vld | out_ready);

    // Hamming distance of exactly one == diff is a non-zero power of two.
    assign w_diff      = in_data ^ r_hist_word;
    assign w_dist_one  = (w_diff != '0) &&
                         ((w_diff & (w_diff - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    // A clear in the same cycle makes this word the first of a new sequence.
    assign w_hist_live = r_hist_vld & ~seq_clr;
    assign w_seq_err   = ~in_mode & w_hist_live & ~w_dist_one;

    // Gray->binary is a running XOR from the MSB down.
    always_comb begin
        w_g2b = '0;
        w_g2b[WIDTH-1] = r_s1_data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_g2b[i] = w_g2b[i+1] ^ r_s1_data[i];
        end
    end

    assign w_b2g  = r_s1_data ^ (r_s1_data >> 1);
    assign w_conv = r_s1_mode ? w_b2g : w_g2b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_mode <= 1'b0;
            r_s1_err  <= 1'b0;
        end else if (w_xfer_in) begin
            r_s1_vld  <= 1'b1;
            r_s1_data <= in_data;
            r_s1_mode <= in_mode;
            r_s1_err  <= w_seq_err;
        end else if (w_s2_load) begin
            r_s1_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
            r_s2_mode <= 1'b0;
            r_s2_err  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_vld  <= 1'b1;
            r_s2_data <= w_conv;
            r_s2_mode <= r_s1_mode;
            r_s2_err  <= r_s1_err;
        end else if (out_ready) begin
            r_s2_vld  <= 1'b0;
        end
    end

    // Only Gray words advance the history; binary words pass through it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist_word <= '0;
            r_hist_vld  <= 1'b0;
        end else if (w_xfer_in && !in_mode) begin
            r_hist_word <= in_data;
            r_hist_vld  <= 1'b1;
        end else if (seq_clr) begin
            r_hist_vld  <= 1'b0;
        end
    end

    assign out_valid   = r_s2_vld;
    assign out_data    = r_s2_data;
    assign out_mode    = r_s2_mode;
    assign out_seq_err = r_s2_err;

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 Parameter WIDTH, default 8, code word width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  block accepts word this cycle.
REQ-006 in_data  input  WIDTH  code word to convert.
REQ-007 in_mode  input  1  0 = Gray->binary, 1 = binary->Gray.
REQ-008 seq_clr  input  1  synchronous clear of Gray-sequence history.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream takes result this cycle.
REQ-011 out_data  output  WIDTH  converted word.
REQ-012 out_mode  output  1  in_mode of the word that produced out_data.
REQ-013 out_seq_err  output  1  Gray adjacency violation flag for the word in out_data.

Function
REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-015 Two register stages, S1 (capture) and S2 (result), each with its own valid bit.
REQ-016 S1 captures in_data, in_mode and the computed sequence flag on transfer in.
REQ-017 S2 loads the S1 word, converted, when S1 valid and (S2 empty or transfer out); S1 valid clears unless refilled the same cycle.
REQ-018 in_ready = ~S1_valid | ~S2_valid | out_ready, combinational; no data loss or duplication under any in_valid/out_ready pattern.
REQ-019 Latency with no stall: word accepted at edge N is on out_data with out_valid=1 after edge N+1; sustained throughput one word per cycle.
REQ-020 Gray->binary: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i] for i=WIDTH-2 down to 0.
REQ-021 Binary->Gray: g[WIDTH-1]=b[WIDTH-1]; g[i]=b[i+1]^b[i].
REQ-022 out_data, out_mode, out_seq_err hold stable while out_valid=1 and out_ready=0.
REQ-023 Sequence history: registers hist_word (WIDTH) and hist_valid (1), updated only on transfer in with in_mode=0.
REQ-024 On mode-0 transfer in, seq flag = hist_valid & (Hamming distance(in_data, hist_word) != 1); then hist_word <= in_data, hist_valid <= 1.
REQ-025 Repeated identical Gray word (distance 0) is an error.
REQ-026 Mode-1 words carry seq flag 0 and leave history untouched.
REQ-027 seq_clr clears hist_valid; with a simultaneous mode-0 transfer in, that word is treated as first (flag 0) and is loaded as new history.
REQ-028 Wrap-around: for WIDTH=4, Gray 4'b1000 followed by 4'b0000 is adjacent (flag 0).
REQ-029 Mode may change per word; mode and data travel together through both stages.

Reset
REQ-030 rst asserted: S1_valid=0, S2_valid=0, hist_valid=0 immediately, independent of clk.
REQ-031 During reset: out_valid=0, out_data=0, out_mode=0, out_seq_err=0, in_ready=1.
REQ-032 Words in flight at reset assertion are discarded; no output after release until a new transfer in.
REQ-033 First mode-0 word after reset release reports out_seq_err=0.

Verification
REQ-034 WIDTH=4, out_ready=1, mode 0, exhaustive inputs 0..15 back-to-back -> each result 2 cycles later; Gray 4'b1000 -> 4'b1111, 4'b1111 -> 4'b1010, one result per cycle.
REQ-035 WIDTH=4, mode 1, binary 4'b0101 -> 4'b0111; 4'b1111 -> 4'b1000; alternating modes per word -> out_mode matches each word.
REQ-036 Mode 0 sequence 0000,0001,0011,0000,0000 -> out_seq_err 0,0,0,1,1; then seq_clr with word 0101 -> 0.
REQ-037 out_ready=0 for 5 cycles with in_valid=1 -> exactly two words buffered, in_ready=0, out_data stable; out_ready=1 -> words delivered in order, none lost or duplicated.
REQ-038 Assert rst asynchronously between edges with both stages full -> out_valid falls immediately; after release, next word 4'b0011 (mode 0) -> 4'b0010, out_seq_err=0.
REQ-039 WIDTH=32 random mode/data with random out_ready -> outputs match reference model, order preserved.
